// File: rtl/mux_pkg.sv
// Shared types and helpers for the mux_arb arbitrated output multiplexer.
package mux_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Index width that never collapses to zero bits, even for a single channel.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_arb_if.sv
// Producer-side and consumer-side handshake bundle of mux_arb.
interface mux_arb_if
  import mux_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = clog2_min1(CHANNELS);

  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_sel;

  // slave is the arbiter's view, master the surrounding producers/consumer.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/mux_arb_rr_arbiter.sv
// Combinational arbiter: fixed priority or round-robin from ptr, with wrap-safe
// next-pointer computation for any channel count.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = clog2_min1(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  input  arb_mode_e           mode,
  input  logic                advance,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic [SEL_W-1:0]    ptr_next
);

  localparam logic [SEL_W:0] CH_EXT = (SEL_W+1)'(CHANNELS);

  logic [SEL_W:0]                     w_ptr_ext;
  logic [CHANNELS-1:0][SEL_W-1:0]     w_dist;
  logic [CHANNELS-1:0][CHANNELS-1:0]  w_hit;
  logic [CHANNELS-1:0]                w_rot;
  logic [SEL_W-1:0][CHANNELS-1:0]     w_idx_cols;

  assign w_ptr_ext = {1'b0, ptr};

  // Search distance of each channel from the starting point (0 in fixed mode).
  genvar gi, gk;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_dist
      localparam logic [SEL_W:0] GI = (SEL_W+1)'(gi);
      logic [SEL_W:0] w_d;
      assign w_d = (mode != ARB_RR)   ? GI :
                   (GI >= w_ptr_ext)  ? (GI - w_ptr_ext) :
                                        (GI + CH_EXT - w_ptr_ext);
      assign w_dist[gi] = w_d[SEL_W-1:0];
    end

    // w_rot[k] is the request of whichever channel sits k steps from the start.
    for (gk = 0; gk < CHANNELS; gk++) begin : g_lvl
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
        assign w_hit[gk][gi] = req[gi] & (w_dist[gi] == SEL_W'(gk));
      end
      assign w_rot[gk] = |w_hit[gk];
    end

    // A requester wins when nobody closer to the start is requesting.
    for (gi = 0; gi < CHANNELS; gi++) begin : g_grant
      assign grant[gi] = req[gi] &
                         ~|(w_rot & ((CHANNELS'(1) << w_dist[gi]) - CHANNELS'(1)));
    end

    for (gk = 0; gk < SEL_W; gk++) begin : g_enc_bit
      for (gi = 0; gi < CHANNELS; gi++) begin : g_enc_ch
        assign w_idx_cols[gk][gi] = 1'((gi >> gk) & 1);
      end
      assign grant_idx[gk] = |(grant & w_idx_cols[gk]);
    end
  endgenerate

  always_comb begin
    ptr_next = ptr;
    if (mode != ARB_RR) begin
      ptr_next = '0;
    end else if (advance) begin
      ptr_next = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
    end
  end

endmodule

// File: rtl/mux_arb.sv
// N-channel arbitrated multiplexer with a single registered output stage
// and valid/ready handshakes on both sides.
module mux_arb
  import mux_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int RR_MODE  = 1
) (
  input logic       clk,
  input logic       rst,
  mux_arb_if.slave  bus
);

  localparam int        SEL_W = clog2_min1(CHANNELS);
  localparam arb_mode_e MODE  = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  logic                           r_out_valid;
  logic [WIDTH-1:0]               r_out_data;
  logic [SEL_W-1:0]               r_out_sel;
  logic [SEL_W-1:0]               r_ptr;

  logic                           w_load;
  logic                           w_xfer;
  logic [CHANNELS-1:0]            w_grant;
  logic [CHANNELS-1:0]            w_in_ready;
  logic [SEL_W-1:0]               w_grant_idx;
  logic [SEL_W-1:0]               w_ptr_next;
  logic [WIDTH-1:0][CHANNELS-1:0] w_cols;
  logic [WIDTH-1:0]               w_sel_data;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arb (
    .req       (bus.in_valid),
    .ptr       (r_ptr),
    .mode      (MODE),
    .advance   (w_xfer),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .ptr_next  (w_ptr_next)
  );

  assign w_load     = !r_out_valid | bus.out_ready;
  // Holding reset suppresses grants so nothing appears accepted during reset.
  assign w_in_ready = w_grant & {CHANNELS{w_load & !rst}};
  assign w_xfer     = |(bus.in_valid & w_in_ready);

  // One-hot AND-OR data select, column by column.
  genvar gi, gb;
  generate
    for (gb = 0; gb < WIDTH; gb++) begin : g_col
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
        assign w_cols[gb][gi] = bus.in_data[gi*WIDTH + gb];
      end
      assign w_sel_data[gb] = |(w_grant & w_cols[gb]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_sel   <= w_grant_idx;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_ptr <= w_ptr_next;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

endmodule
